sd_dac_modulator: RTL and testbench

- Transmit-side counterpart of the CIC decimator. Accepts parallel unsigned samples at the output-sample rate and emits a 1-bit sigma-delta bitstream at the clock rate.
- Zero-order hold over OSR+1 clocks, followed by a first-order error-feedback (accumulator-carry) modulator.
- Drives an external analog low-pass / sigma-delta DAC pin.
- The sample period counter matches the decimator's (OSR+1 clocks), so both ends run at the same sample rate.

---
 rtl/sd_dac_modulator.sv | 105 ++++++++++
 tb/tb_sd_dac_modulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac_modulator.sv
// First-order sigma-delta DAC: one-deep sample buffer, zero-order hold over OSR+1 clocks, carry-out bitstream.
// Latency: first sdo bit of a new sample 2 clocks after the hit cycle; din_ready is registered (!buf_full), no comb path from din_valid.
module sd_dac_modulator #(
    parameter int                   OSR_WIDTH  = 7,
    parameter int                   DATA_WIDTH = 3 * OSR_WIDTH,
    parameter logic [OSR_WIDTH-1:0] OSR        = '1,
    parameter int                   UCNT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  sdo,
    output logic                  tick,
    output logic                  underrun,
    output logic [UCNT_WIDTH-1:0] underrun_cnt
);

    logic [OSR_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  running_q, running_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  sdo_q, sdo_d;
    logic                  tick_q, tick_d;
    logic                  underrun_q, underrun_d;
    logic [UCNT_WIDTH-1:0] ucnt_q, ucnt_d;

    logic                  hit;
    logic                  accept;
    logic [DATA_WIDTH:0]   acc_sum;

    always_comb begin
        hit        = (cnt_q == OSR);
        accept     = din_valid && !buf_full_q;

        cnt_d      = hit ? '0 : cnt_q + OSR_WIDTH'(1);
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        active_d   = active_q;
        running_d  = running_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        tick_d     = hit;

        // A full buffer blocks accept, so load-and-clear never collides with a write.
        if (hit) begin
            if (buf_full_q) begin
                active_d   = buf_data_q;
                buf_full_d = 1'b0;
                running_d  = 1'b1;
            end else if (running_q) begin
                underrun_d = 1'b1;
                if (ucnt_q != '1) begin
                    ucnt_d = ucnt_q + UCNT_WIDTH'(1);
                end
            end
        end

        if (accept) begin
            buf_data_d = din;
            buf_full_d = 1'b1;
        end

        // Only the residue is stored; the carry of the sum is the output bit.
        acc_sum = {1'b0, acc_q} + {1'b0, active_q};
        acc_d   = acc_sum[DATA_WIDTH-1:0];
        sdo_d   = acc_sum[DATA_WIDTH];
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            cnt_q      <= '0;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            active_q   <= '0;
            running_q  <= 1'b0;
            acc_q      <= '0;
            sdo_q      <= 1'b0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
            active_q   <= active_d;
            running_q  <= running_d;
            acc_q      <= acc_d;
            sdo_q      <= sdo_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign din_ready    = !buf_full_q;
    assign sdo          = sdo_q;
    assign tick         = tick_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_sd_dac_modulator.sv
// Directed bench for sd_dac_modulator with DATA_WIDTH=4, OSR_WIDTH=3, OSR=7 and a 3-bit underrun counter.
module tb_sd_dac_modulator;

    logic       clk = 1'b0;
    logic       sclr;
    logic [3:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sdo;
    logic       tick;
    logic       underrun;
    logic [2:0] underrun_cnt;

    int errors = 0;
    int checks = 0;

    sd_dac_modulator #(
        .OSR_WIDTH (3),
        .DATA_WIDTH(4),
        .OSR       (3'd7),
        .UCNT_WIDTH(3)
    ) dut (
        .clock       (clk),
        .sclr        (sclr),
        .din         (din),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .sdo         (sdo),
        .tick        (tick),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] din;
        int         ones;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps at least once, stops on the first tick seen.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 20);
        chk("wait_tick", {31'd0, tick}, 1);
    endtask

    task automatic send(input logic [3:0] d, input bit keep);
        logic took;
        int   n;
        took = 1'b0;
        n = 0;
        din = d;
        din_valid = 1'b1;
        while (!took && n < 20) begin
            took = din_ready;
            step();
            n++;
        end
        if (!keep) din_valid = 1'b0;
        chk("send_accept", {31'd0, took}, 1);
    endtask

    task automatic run_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            ones += int'(sdo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t       vecs[7];
        logic [7:0] bp_bits;
        int         ones;
        int         ones2;

        vecs[0] = '{din: 4'd15, ones: 15};
        vecs[1] = '{din: 4'd0,  ones: 0};
        vecs[2] = '{din: 4'd8,  ones: 8};
        vecs[3] = '{din: 4'd3,  ones: 3};
        vecs[4] = '{din: 4'd10, ones: 10};
        vecs[5] = '{din: 4'd1,  ones: 1};
        vecs[6] = '{din: 4'd12, ones: 12};
        bp_bits = 8'b0010_0000;

        // Reset with a sample offered; it must be discarded.
        sclr = 1'b1;
        din = 4'd5;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sdo", {31'd0, sdo}, 0);
            chk("rst_tick", {31'd0, tick}, 0);
            chk("rst_underrun", {31'd0, underrun}, 0);
            chk("rst_ucnt", {29'd0, underrun_cnt}, 0);
        end
        sclr = 1'b0;
        din_valid = 1'b0;
        chk("rst_ready", {31'd0, din_ready}, 1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("idle_sdo", {31'd0, sdo}, 0);
            chk("idle_underrun", {31'd0, underrun}, 0);
        end

        // Backpressure from clean residue: 3 accepted mid-period, 9 held off until after the hit.
        wait_tick();
        step();
        step();
        chk("bp_ready_idle", {31'd0, din_ready}, 1);
        din = 4'd3;
        din_valid = 1'b1;
        step();
        chk("bp_ready_low", {31'd0, din_ready}, 0);
        din = 4'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold", {31'd0, din_ready}, 0);
        end
        step();
        chk("bp_tick", {31'd0, tick}, 1);
        chk("bp_ready_rise", {31'd0, din_ready}, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                chk("bp_accept9", {31'd0, din_ready}, 0);
                din_valid = 1'b0;
            end
            chk("bp_sdo3", {31'd0, sdo}, {31'd0, bp_bits[i]});
        end
        chk("bp_tick2", {31'd0, tick}, 1);
        run_ones(16, ones);
        chk("bp_density9", ones, 9);

        // Half scale from clean residue, sample kept on offer every period.
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        send(4'd8, 1'b1);
        wait_tick();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("half_sdo", {31'd0, sdo}, i % 2);
            chk("half_underrun", {31'd0, underrun}, 0);
            ones += int'(sdo);
        end
        chk("half_density", ones, 8);

        // Density table; the held sample stays active across the 16-clock window.
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].din, 1'b0);
            wait_tick();
            run_ones(16, ones);
            chk($sformatf("density_%0d", vecs[v].din), ones, vecs[v].ones);
        end

        // Underrun: one sample then starvation, counter saturates at 7.
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        chk("ur_cnt_rst", {29'd0, underrun_cnt}, 0);
        send(4'd10, 1'b0);
        wait_tick();
        ones = 0;
        ones2 = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("ur_pulse", {31'd0, underrun}, (k % 8 == 0) ? 1 : 0);
            if (k == 8) chk("ur_cnt1", {29'd0, underrun_cnt}, 1);
            if (k <= 16) ones += int'(sdo);
            else ones2 += int'(sdo);
        end
        chk("ur_cnt4", {29'd0, underrun_cnt}, 4);
        chk("ur_density_a", ones, 10);
        chk("ur_density_b", ones2, 10);
        for (int k = 1; k <= 32; k++) step();
        chk("ur_cnt_sat", {29'd0, underrun_cnt}, 7);
        chk("ur_pulse_sat", {31'd0, underrun}, 1);

        // Mid-stream reset with buffer full and active=12.
        send(4'd12, 1'b0);
        wait_tick();
        send(4'd5, 1'b0);
        chk("mr_full", {31'd0, din_ready}, 0);
        sclr = 1'b1;
        din = 4'd7;
        din_valid = 1'b1;
        step();
        sclr = 1'b0;
        din_valid = 1'b0;
        chk("mr_sdo", {31'd0, sdo}, 0);
        chk("mr_tick", {31'd0, tick}, 0);
        chk("mr_underrun", {31'd0, underrun}, 0);
        chk("mr_ucnt", {29'd0, underrun_cnt}, 0);
        chk("mr_ready", {31'd0, din_ready}, 1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("mr_idle_sdo", {31'd0, sdo}, 0);
            chk("mr_idle_underrun", {31'd0, underrun}, 0);
            chk("mr_tick_phase", {31'd0, tick}, (k == 8 || k == 16) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
